config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_sequencer_pkg.sv | 41 ++++
 rtl/config_rom.sv | 48 ++++
 rtl/config_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_config_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// config_sequencer_pkg
// Shared definitions for the configuration sequencer slice:
//   - seq_state_t : sequencer state enumeration (readback states only exist
//                   when CONFIG_SEQ_READBACK_EN is defined)
//   - CMD_WR/CMD_RD : encodings driven on cmd_rw
//   - cfg_entry_t : one table entry {addr, data} at the native 8/16-bit size
//   - cnt_width() : width helper for the gap/timeout counters
// Optional feature macro: CONFIG_SEQ_READBACK_EN
// ---------------------------------------------------------------------------
package config_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CMD,
    ST_WAIT_RSP,
    ST_GAP,
    ST_DONE,
    ST_FAIL
`ifdef CONFIG_SEQ_READBACK_EN
    , ST_RD_CMD,
    ST_RD_WAIT,
    ST_CHECK
`endif
  } seq_state_t;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cfg_entry_t;

  // Counters need at least one bit even when the count they hold is 0 or 1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/config_rom.sv
// ---------------------------------------------------------------------------
// config_rom
// Combinational lookup of the register configuration table.
// Ports:
//   index : table entry number (8 bits)
//   addr  : register address of that entry (ADDR_W bits)
//   data  : value written to that register (DATA_W bits)
// Indices beyond NUM_REGS-1 return zero. Entries past the eight listed
// ones are generated from the index so any NUM_REGS up to 255 is populated.
// ---------------------------------------------------------------------------
module config_rom
  import config_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
) (
  input  logic [7:0]        index,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam logic [7:0] LAST_INDEX = 8'(NUM_REGS - 1);

  cfg_entry_t entry;

  // Table contents; the sequencer only ever sees the resized addr/data.
  always_comb begin
    entry = '0;
    if (index <= LAST_INDEX) begin
      case (index)
        8'd0:    entry = '{addr: 8'h10, data: 16'hA5A5};
        8'd1:    entry = '{addr: 8'h14, data: 16'h0F0F};
        8'd2:    entry = '{addr: 8'h18, data: 16'h1234};
        8'd3:    entry = '{addr: 8'h1C, data: 16'hBEEF};
        8'd4:    entry = '{addr: 8'h20, data: 16'h00FF};
        8'd5:    entry = '{addr: 8'h24, data: 16'hFF00};
        8'd6:    entry = '{addr: 8'h28, data: 16'hC0DE};
        8'd7:    entry = '{addr: 8'h2C, data: 16'h55AA};
        default: entry = '{addr: index, data: {index, ~index}};
      endcase
    end
  end

  assign addr = ADDR_W'(entry.addr);
  assign data = DATA_W'(entry.data);

endmodule

// File: rtl/config_sequencer.sv
// ---------------------------------------------------------------------------
// config_sequencer
// Walks the configuration table held in config_rom and issues one write per
// entry to a serial master, waiting for each completion pulse and inserting
// an idle gap between transactions.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : single-cycle request to run the table
//   cmd_valid/cmd_rw/cmd_addr/cmd_wdata : command to the serial master
//   cmd_ready             : serial master accepts the command
//   rsp_valid/rsp_rdata   : transaction-complete pulse and read data
//   busy/done/error/err_index : run status
// Optional feature macro: CONFIG_SEQ_READBACK_EN -- each write is followed
// by a read of the same address whose data must match the table entry.
// Without it cmd_rw is tied to write and rsp_rdata is not used.
// ---------------------------------------------------------------------------
module config_sequencer
  import config_sequencer_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cmd_valid,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        err_index
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

  localparam logic [7:0]       LAST_INDEX = 8'(NUM_REGS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state;
  logic [7:0]        index;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

`ifdef CONFIG_SEQ_READBACK_EN
  logic              cmd_rw_q;
  logic [DATA_W-1:0] rdata_q;

  assign cmd_rw = cmd_rw_q;
`else
  assign cmd_rw = CMD_WR;
`endif

  config_rom #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_rom (
    .index (index),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  // Single sequencer FSM; every output is a register. The gap counter holds
  // the remaining idle clocks (a load of 0 still spends one clock in GAP),
  // and the timeout counter restarts on every accepted command so reads and
  // writes get the same allowance. Reaching the last index ends the run
  // instead of incrementing, so index never passes NUM_REGS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
`ifdef CONFIG_SEQ_READBACK_EN
      cmd_rw_q  <= CMD_WR;
      rdata_q   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            index     <= '0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          cmd_addr  <= rom_addr;
          cmd_wdata <= rom_data;
          cmd_valid <= 1'b1;
`ifdef CONFIG_SEQ_READBACK_EN
          cmd_rw_q  <= CMD_WR;
`endif
          state     <= ST_CMD;
        end

        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_WAIT_RSP;
          end
        end

        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else if (tmo_cnt == TMO_LAST) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= index;
            state     <= ST_FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt > GAP_ONE) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            gap_cnt <= '0;
`ifdef CONFIG_SEQ_READBACK_EN
            cmd_valid <= 1'b1;
            cmd_rw_q  <= CMD_RD;
            state     <= ST_RD_CMD;
`else
            if (index == LAST_INDEX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              index <= index + 1'b1;
              state <= ST_FETCH;
            end
`endif
          end
        end

`ifdef CONFIG_SEQ_READBACK_EN
        ST_RD_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_rw_q  <= CMD_WR;
            tmo_cnt   <= '0;
            state     <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (rsp_valid) begin
            rdata_q <= rsp_rdata;
            state   <= ST_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= index;
            state     <= ST_FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // cmd_wdata still holds the table value written for this entry.
        ST_CHECK: begin
          if (rdata_q != cmd_wdata) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= index;
            state     <= ST_FAIL;
          end else if (index == LAST_INDEX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            index <= index + 1'b1;
            state <= ST_FETCH;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_config_sequencer
// Self-checking bench for config_sequencer (NUM_REGS=3, GAP_CYCLES=2,
// TIMEOUT_CYCLES=20). The bench plays the serial master with randomized
// ready/response delays and predicts the command order from the table and
// the run latency as a sum of per-transaction clock costs.
// ---------------------------------------------------------------------------
module tb_config_sequencer;

  localparam int NUM_REGS       = 3;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int GAP_EFF        = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

  localparam logic [7:0]  TBL_ADDR [NUM_REGS] = '{8'h10, 8'h14, 8'h18};
  localparam logic [15:0] TBL_DATA [NUM_REGS] = '{16'hA5A5, 16'h0F0F, 16'h1234};

  logic        clk;
  logic        reset;
  logic        start;
  logic        cmd_valid;
  logic        cmd_rw;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  err_index;

  int passCount  = 0;
  int checkCount = 0;
  int cycleCount = 0;

  config_sequencer #(
    .NUM_REGS       (NUM_REGS),
    .ADDR_W         (8),
    .DATA_W         (16),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cmd_valid (cmd_valid),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One-cycle start pulse; returns on the negedge after start was sampled.
  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cmd_valid"}, cmd_valid, 0);
    checkOutput({tag, "_cmd_rw"},    cmd_rw,    0);
    checkOutput({tag, "_cmd_addr"},  cmd_addr,  0);
    checkOutput({tag, "_cmd_wdata"}, cmd_wdata, 0);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_done"},      done,      0);
    checkOutput({tag, "_error"},     error,     0);
    checkOutput({tag, "_err_index"}, err_index, 0);
  endtask

  // Serial-master model for one transaction: wait for the command, hold
  // ready low for readyDelay clocks (checking the command stays put), accept
  // it, then pulse rsp_valid so it is sampled rspDelay clocks after accept.
  // noise injects a spurious start and rsp_valid while the command waits.
  task automatic serveCmd(input string tag, input logic expRw, input logic [7:0] expAddr,
                          input logic [15:0] expData, input int readyDelay, input int rspDelay,
                          input bit giveRsp, input logic [15:0] rdata, input bit noise);
    int waitCount;
    bit stable;
    waitCount = 0;
    while (cmd_valid !== 1'b1 && waitCount < 200) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput({tag, "_valid"}, cmd_valid, 1);
    checkOutput({tag, "_addr"}, cmd_addr, expAddr);
    checkOutput({tag, "_rw"}, cmd_rw, expRw);
    if (expRw == 1'b0) checkOutput({tag, "_wdata"}, cmd_wdata, expData);
    if (noise) begin
      start     = 1'b1;
      rsp_valid = 1'b1;
    end
    stable = 1'b1;
    for (int i = 0; i < readyDelay; i++) begin
      @(negedge clk);
      start     = 1'b0;
      rsp_valid = 1'b0;
      if (cmd_valid !== 1'b1 || cmd_addr !== expAddr || cmd_rw !== expRw ||
          (expRw == 1'b0 && cmd_wdata !== expData) || error !== 1'b0)
        stable = 1'b0;
    end
    if (readyDelay > 0) checkOutput({tag, "_stable"}, stable, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    start     = 1'b0;
    rsp_valid = 1'b0;
    checkOutput({tag, "_dropped"}, cmd_valid, 0);
    if (giveRsp) begin
      for (int i = 1; i < rspDelay; i++) @(negedge clk);
      rsp_valid = 1'b1;
      rsp_rdata = rdata;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_rdata = $urandom();
    end
  endtask

  // Full run from a start pulse. Expected latency (start edge to done edge)
  // is the sum over entries of fetch+command (2) + ready wait + response
  // wait + gap, plus 2 + ready wait + response wait for each readback.
  task automatic runSequence(input string tag, input bit fixedTiming, input int holdEntry0,
                             input bit noise, input int timeoutIdx, input int corruptIdx);
    int readyDelay, rspDelay, expLatency, startStamp, waitCount;
    logic [15:0] readData;
    expLatency = 0;
    applyStimulus();
    startStamp = cycleCount;
    checkOutput({tag, "_busy_start"}, busy, 1);
    checkOutput({tag, "_done_clr"}, done, 0);
    checkOutput({tag, "_error_clr"}, error, 0);
    for (int e = 0; e < NUM_REGS; e++) begin
      readyDelay = fixedTiming ? 0 : int'($urandom_range(0, 3));
      if (e == 0 && holdEntry0 >= 0) readyDelay = holdEntry0;
      rspDelay = fixedTiming ? 4 : int'($urandom_range(1, 6));
      if (e == timeoutIdx) begin
        serveCmd($sformatf("%s_wr%0d", tag, e), 1'b0, TBL_ADDR[e], TBL_DATA[e],
                 readyDelay, 0, 1'b0, 16'h0, 1'b0);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        checkOutput({tag, "_error_early"}, error, 0);
        @(negedge clk);
        checkOutput({tag, "_timeout_error"}, error, 1);
        checkOutput({tag, "_timeout_index"}, err_index, e);
        checkOutput({tag, "_timeout_busy"}, busy, 0);
        checkOutput({tag, "_timeout_done"}, done, 0);
        return;
      end
      serveCmd($sformatf("%s_wr%0d", tag, e), 1'b0, TBL_ADDR[e], TBL_DATA[e],
               readyDelay, rspDelay, 1'b1, 16'h0, noise && (e == 1));
      expLatency += 2 + readyDelay + rspDelay + GAP_EFF;
`ifdef CONFIG_SEQ_READBACK_EN
      readyDelay = fixedTiming ? 0 : int'($urandom_range(0, 3));
      rspDelay   = fixedTiming ? 4 : int'($urandom_range(1, 6));
      readData   = TBL_DATA[e] ^ ((e == corruptIdx) ? 16'h0001 : 16'h0000);
      serveCmd($sformatf("%s_rd%0d", tag, e), 1'b1, TBL_ADDR[e], TBL_DATA[e],
               readyDelay, rspDelay, 1'b1, readData, 1'b0);
      if (e == corruptIdx) begin
        @(negedge clk);
        checkOutput({tag, "_rb_error"}, error, 1);
        checkOutput({tag, "_rb_index"}, err_index, e);
        checkOutput({tag, "_rb_busy"}, busy, 0);
        return;
      end
      expLatency += 2 + readyDelay + rspDelay;
`else
      readData = 16'h0;
      if (corruptIdx == e && readData != 16'h0) $display("[TB] readback disabled");
`endif
    end
    waitCount = 0;
    while (done !== 1'b1 && waitCount < 200) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_end"}, busy, 0);
    checkOutput({tag, "_error_end"}, error, 0);
    checkOutput({tag, "_latency"}, cycleCount - startStamp, expLatency);
  endtask

  initial begin
    bit idleOk;
    reset     = 1'b1;
    start     = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 16'h0;

    // Reset state and no automatic run after release
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    idleOk = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0) idleOk = 1'b0;
    end
    checkOutput("no_auto_run", idleOk, 1);

    $display("[TB] deterministic run");
    runSequence("basic", 1'b1, -1, 1'b0, -1, -1);

    $display("[TB] randomized runs with spurious start/rsp_valid");
    for (int r = 0; r < 3; r++) runSequence($sformatf("rand%0d", r), 1'b0, -1, 1'b1, -1, -1);

    $display("[TB] long cmd_ready hold");
    runSequence("hold", 1'b1, 50, 1'b0, -1, -1);

    $display("[TB] response timeout on entry 1");
    runSequence("tmo", 1'b0, -1, 1'b0, 1, -1);
    runSequence("after_tmo", 1'b0, -1, 1'b0, -1, -1);

    $display("[TB] reset during WAIT_RSP of entry 2");
    applyStimulus();
    for (int e = 0; e < 2; e++) begin
      serveCmd($sformatf("rst_wr%0d", e), 1'b0, TBL_ADDR[e], TBL_DATA[e], 0, 4, 1'b1, 16'h0, 1'b0);
`ifdef CONFIG_SEQ_READBACK_EN
      serveCmd($sformatf("rst_rd%0d", e), 1'b1, TBL_ADDR[e], TBL_DATA[e], 0, 2, 1'b1,
               TBL_DATA[e], 1'b0);
`endif
    end
    serveCmd("rst_wr2", 1'b0, TBL_ADDR[2], TBL_DATA[2], 1, 0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    #3 reset = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    idleOk = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) idleOk = 1'b0;
    end
    checkOutput("idle_after_reset", idleOk, 1);
    runSequence("after_reset", 1'b0, -1, 1'b0, -1, -1);

`ifdef CONFIG_SEQ_READBACK_EN
    $display("[TB] readback mismatch on entry 0");
    runSequence("rb_bad", 1'b0, -1, 1'b0, -1, 0);
    runSequence("rb_good", 1'b0, -1, 1'b0, -1, -1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
